// File: rtl/cnn_pkg.sv
// Shared types and image geometry for the CNN sequencer and its pixel unpacker.
// The image arrives as 98 packed bytes and is stored as 784 single-bit RAM words.
package cnn_pkg;

    typedef enum logic [2:0] {
        LOAD,
        UNPACK,
        RUN,
        SEND,
        ERR
    } state_t;

    localparam int IMG_BYTES = 98;
    localparam int IMG_BITS  = 784;
    localparam int IMG_AW    = 10;
    localparam int LABEL_W   = 4;

    // Byte n of the image covers pixels 8*n .. 8*n+7.
    function automatic logic [IMG_AW-1:0] byte_base(input logic [6:0] n);
        return {n, 3'b000};
    endfunction

endpackage

// File: rtl/img_unpacker.sv
// Latches one received byte and writes its 8 bits to the input RAM, LSB first,
// one bit per cycle starting the cycle after load; no backpressure, load is only issued when idle.
module img_unpacker
    import cnn_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [7:0]        byte_in,
    input  logic [IMG_AW-1:0] base_addr,
    output logic              we,
    output logic [IMG_AW-1:0] addr,
    output logic              wdata,
    output logic              last_bit
);

    logic [7:0] byte_q;
    logic [2:0] bit_cnt;

    assign last_bit = we && (bit_cnt == 3'd7);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_q  <= '0;
            bit_cnt <= '0;
            we      <= 1'b0;
            addr    <= '0;
            wdata   <= 1'b0;
        end else if (load) begin
            byte_q  <= byte_in;
            bit_cnt <= '0;
            we      <= 1'b1;
            addr    <= base_addr;
            wdata   <= byte_in[0];
        end else if (we) begin
            if (bit_cnt == 3'd7) begin
                we    <= 1'b0;
                wdata <= 1'b0;
            end else begin
                bit_cnt <= bit_cnt + 3'd1;
                addr    <= addr + IMG_AW'(1);
                wdata   <= byte_q[bit_cnt + 3'd1];
            end
        end
    end

endmodule

// File: rtl/cnn_sequencer.sv
// Loads a packed 28x28 binary image from the UART, runs the layer engines in order and
// transmits the label (or ERR_CODE); every output is registered, trmt waits for tx_busy low.
module cnn_sequencer
    import cnn_pkg::*;
#(
    parameter int          NUM_LAYERS = 5,
    parameter int          TIMEOUT    = 65535,
    parameter logic [7:0]  ERR_CODE   = 8'hEE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_rdy,
    input  logic [7:0]            rx_data,
    output logic                  img_we,
    output logic [IMG_AW-1:0]     img_addr,
    output logic                  img_wdata,
    output logic [NUM_LAYERS-1:0] layer_start,
    input  logic [NUM_LAYERS-1:0] layer_done,
    input  logic [LABEL_W-1:0]    pred_label,
    input  logic                  tx_busy,
    output logic                  trmt,
    output logic [7:0]            tx_data,
    output logic                  busy,
    output logic                  err
);

    localparam int LIW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam int WDW = $clog2(TIMEOUT + 1);

    state_t                state, state_nxt;
    logic [6:0]            byte_cnt, byte_cnt_nxt;
    logic [LIW-1:0]        layer_idx, layer_idx_nxt;
    logic [WDW-1:0]        wd_cnt, wd_cnt_nxt;
    logic [LABEL_W-1:0]    label, label_nxt;
    logic                  overrun, overrun_nxt;
    logic [NUM_LAYERS-1:0] start_nxt;
    logic                  trmt_nxt;
    logic [7:0]            tx_data_nxt;
    logic                  err_nxt;
    logic                  load;
    logic                  last_bit;

    img_unpacker u_unpacker (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .byte_in   (rx_data),
        .base_addr (byte_base(byte_cnt)),
        .we        (img_we),
        .addr      (img_addr),
        .wdata     (img_wdata),
        .last_bit  (last_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= LOAD;
            byte_cnt    <= '0;
            layer_idx   <= '0;
            wd_cnt      <= '0;
            label       <= '0;
            overrun     <= 1'b0;
            layer_start <= '0;
            trmt        <= 1'b0;
            tx_data     <= '0;
            busy        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= state_nxt;
            byte_cnt    <= byte_cnt_nxt;
            layer_idx   <= layer_idx_nxt;
            wd_cnt      <= wd_cnt_nxt;
            label       <= label_nxt;
            overrun     <= overrun_nxt;
            layer_start <= start_nxt;
            trmt        <= trmt_nxt;
            tx_data     <= tx_data_nxt;
            busy        <= (state_nxt != LOAD);
            err         <= err_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        byte_cnt_nxt  = byte_cnt;
        layer_idx_nxt = layer_idx;
        wd_cnt_nxt    = wd_cnt;
        label_nxt     = label;
        overrun_nxt   = overrun;
        start_nxt     = '0;
        trmt_nxt      = 1'b0;
        tx_data_nxt   = tx_data;
        err_nxt       = err;
        load          = 1'b0;

        case (state)
            LOAD: begin
                if (rx_rdy) begin
                    load      = 1'b1;
                    state_nxt = UNPACK;
                end
            end

            UNPACK: begin
                // A byte arriving while bits are still being written cannot be stored.
                if (rx_rdy) begin
                    overrun_nxt = 1'b1;
                    err_nxt     = 1'b1;
                end
                if (last_bit) begin
                    byte_cnt_nxt = byte_cnt + 7'd1;
                    if (overrun || rx_rdy) begin
                        state_nxt = ERR;
                    end else if (byte_cnt == 7'(IMG_BYTES - 1)) begin
                        state_nxt     = RUN;
                        layer_idx_nxt = '0;
                        wd_cnt_nxt    = '0;
                        start_nxt     = NUM_LAYERS'(1);
                    end else begin
                        state_nxt = LOAD;
                    end
                end
            end

            RUN: begin
                // A done pulse in the expiry cycle still counts as success.
                if (layer_done[layer_idx]) begin
                    wd_cnt_nxt = '0;
                    if (layer_idx != LIW'(NUM_LAYERS - 1)) begin
                        layer_idx_nxt = layer_idx + LIW'(1);
                        start_nxt     = NUM_LAYERS'(1) << (layer_idx + LIW'(1));
                    end else begin
                        label_nxt = pred_label;
                        if (!tx_busy) begin
                            trmt_nxt     = 1'b1;
                            tx_data_nxt  = {{(8-LABEL_W){1'b0}}, pred_label};
                            byte_cnt_nxt = '0;
                            state_nxt    = LOAD;
                        end else begin
                            state_nxt = SEND;
                        end
                    end
                end else if (wd_cnt == WDW'(TIMEOUT - 1)) begin
                    err_nxt    = 1'b1;
                    wd_cnt_nxt = '0;
                    state_nxt  = ERR;
                end else begin
                    wd_cnt_nxt = wd_cnt + WDW'(1);
                end
            end

            SEND: begin
                if (!tx_busy) begin
                    trmt_nxt     = 1'b1;
                    tx_data_nxt  = {{(8-LABEL_W){1'b0}}, label};
                    byte_cnt_nxt = '0;
                    state_nxt    = LOAD;
                end
            end

            ERR: begin
                if (!tx_busy) begin
                    trmt_nxt      = 1'b1;
                    tx_data_nxt   = ERR_CODE;
                    byte_cnt_nxt  = '0;
                    layer_idx_nxt = '0;
                    overrun_nxt   = 1'b0;
                    state_nxt     = LOAD;
                end
            end

            default: state_nxt = LOAD;
        endcase
    end

endmodule

// File: doc/cnn_sequencer.md
# cnn_sequencer

Top-level controller for the CNN core. Collects the 98 UART bytes of a 28x28 binary image and unpacks them bit-serially into the 784x1 input RAM. It then fires the five layer engines (conv_0, max_0, conv_1, max_1, dense_4) in order using start/done handshakes, and hands the predicted label to the UART transmitter. A per-layer watchdog turns a hung engine into a reported error instead of a silent lockup.

## Interface
- NUM_LAYERS, 5, layer engines sequenced in index order 0..NUM_LAYERS-1
- TIMEOUT, 65535, max cycles from layer_start[k] to layer_done[k]
- ERR_CODE, 8'hEE, byte transmitted on error
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- rx_rdy  in  1  one-cycle pulse, rx_data valid
- rx_data  in  8  received byte; bit j maps to pixel 8*n+j for byte n
- img_we  out  1  input RAM write enable
- img_addr  out  10  input RAM address, 0..783
- img_wdata  out  1  pixel bit
- layer_start  out  NUM_LAYERS  one-hot, one-cycle start pulse
- layer_done  in  NUM_LAYERS  one-cycle completion pulses
- pred_label  in  4  class index, valid in the cycle layer_done[NUM_LAYERS-1] is high
- tx_busy  in  1  UART transmitter busy
- trmt  out  1  one-cycle transmit request
- tx_data  out  8  byte to transmit, held until next trmt
- busy  out  1  high in any state other than LOAD
- err  out  1  sticky error flag

## Operation
- States: LOAD, UNPACK, RUN, SEND, ERR.
- LOAD:
  - On rx_rdy, latch rx_data, clear bit_cnt, go to UNPACK.
  - byte_cnt (7 bits) counts 0..97.
- UNPACK: for 8 cycles:
  - img_we=1
  - img_addr = byte_cnt*8 + bit_cnt
  - img_wdata = latched[bit_cnt]
  - After bit 7, increment byte_cnt. If it was 97, go to RUN with layer_idx=0 and pulse layer_start[0]; otherwise return to LOAD.
- RUN:
  - Wait for layer_done[layer_idx]. On it, clear the watchdog.
  - If layer_idx < NUM_LAYERS-1, increment layer_idx and pulse the next layer_start.
  - Otherwise latch pred_label and go to SEND.
- SEND:
  - When tx_busy=0, pulse trmt with tx_data = {4'h0, label}.
  - Clear byte_cnt and go to LOAD.
- ERR:
  - When tx_busy=0, pulse trmt with tx_data = ERR_CODE.
  - Clear byte_cnt and layer_idx, go to LOAD. err stays 1.
- Watchdog: counts cycles in RUN. When it reaches TIMEOUT with no done, set err and go to ERR.
- Overrun: rx_rdy in UNPACK drops the byte, sets err, and goes to ERR once the current byte's 8 writes finish.
- rx_rdy in RUN, SEND or ERR is ignored with no error.
- layer_done for any index other than layer_idx is ignored.
- layer_done[layer_idx] in the same cycle as watchdog expiry counts as a success; done wins.
- Reset:
  - All state to LOAD, all counters 0.
  - Outputs 0: img_*, layer_start, trmt, tx_data, busy, err.
  - Reset mid-UNPACK or mid-RUN aborts with no further writes or starts.

## Timing
- rx_rdy at edge t: img_we high for cycles t+1..t+8, addresses ascending.
- Minimum rx_rdy spacing is 9 cycles. Closer spacing is an overrun.
- Last bit of byte 97 at cycle u: layer_start[0] at u+1.
- layer_done[k] at cycle d: layer_start[k+1] at d+1.
- Last done at d: SEND at d+1; trmt at d+1 if tx_busy=0, otherwise at the first cycle tx_busy is low.
- All outputs are registered. No combinational path from inputs to outputs.

## Structure
- cnn_pkg:
  - state enum: LOAD, UNPACK, RUN, SEND, ERR
  - IMG_BYTES=98, IMG_BITS=784, IMG_AW=10, LABEL_W=4
- Sub-module img_unpacker:
  - Contents: byte latch, bit_cnt, address generation.
  - Ports: load, byte_in, base_addr, we/addr/wdata, last_bit.
- Sequencer FSM, watchdog and TX path stay in cnn_sequencer.

## Test plan
- Full image load:
  - Stimulus: 98 bytes, rx_rdy every 11 cycles.
  - Response: RAM mirror equals source bits (784 compares); exactly 784 img_we cycles; layer_start[0] exactly once, one cycle after the last write.
- Layer chaining:
  - Stimulus: stub engines with done latencies 10, 3, 7, 2, 5 and pred_label=5.
  - Response: start k+1 exactly 1 cycle after done k; trmt once with tx_data=8'h05; busy drops in the same cycle.
- Watchdog:
  - Stimulus: TIMEOUT=100; stub 2 never completes.
  - Response: err=1 exactly 100 cycles after layer_start[2]; trmt with tx_data=8'hEE; next image still accepted with err held at 1.
- Overrun:
  - Stimulus: second rx_rdy 4 cycles after the first.
  - Response: first byte fully written (8 writes); no writes from the second byte; err=1; ERR_CODE transmitted.
- TX stall:
  - Stimulus: tx_busy held high 50 cycles after the last done.
  - Response: trmt on the first cycle tx_busy=0, exactly one pulse; tx_data stable.
- Reset mid-run:
  - Stimulus: rst asserted during layer 1.
  - Response: all outputs 0 asynchronously; after release, a fresh 98-byte load sequences normally with no stray layer_start.
